// File: rtl/gcd_sequencer_if.sv
// Purpose : bundles the sequencer's upstream operand port, downstream result
//           port and the 4-phase req/ack link to the subtract-loop gcd engine.
// Latency : n/a (wiring only).
// Backpr. : in_valid/in_ready and out_valid/out_ready; gcd_req/gcd_ack 4-phase.
// Modports: master = sequencer side (drives in_ready, out_*, gcd_req, gcd_ab);
//           slave  = environment side (upstream producer, consumer, engine).
interface gcd_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_timeout;
  logic             gcd_req;
  logic [WIDTH-1:0] gcd_ab;
  logic             gcd_ack;
  logic [WIDTH-1:0] gcd_c;

  modport master (
    input  in_valid, in_a, in_b, out_ready, gcd_ack, gcd_c,
    output in_ready, out_valid, out_result, out_timeout, gcd_req, gcd_ab
  );

  modport slave (
    output in_valid, in_a, in_b, out_ready, gcd_ack, gcd_c,
    input  in_ready, out_valid, out_result, out_timeout, gcd_req, gcd_ab
  );
endinterface

// File: rtl/gcd_sequencer.sv
// Purpose : front end for the gcd engine; takes an (A,B) pair, sends A then B
//           over the shared AB bus with 4-phase req/ack, returns C.
// Latency : zero operand -> result 1 cycle after accept; otherwise 4 handshake
//           cycles plus engine latency.
// Backpr. : in_ready only in IDLE; result held in DONE until out_ready.
// Ports   : clk, reset (async, active-high); bus (gcd_sequencer_if.master):
//           in_valid/in_ready/in_a/in_b, out_valid/out_ready/out_result/
//           out_timeout, gcd_req/gcd_ab/gcd_ack/gcd_c.
// Options : define GCD_SEQ_TIMEOUT_EN to abort the B phase after
//           TIMEOUT_CYCLES cycles without ack (result 0, out_timeout=1).
module gcd_sequencer #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic          clk,
  input  logic          reset,
  gcd_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    REL_A,
    SEND_B,
    REL_B,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb;
  logic [WIDTH-1:0] res_q;
  logic             to_q;

  logic             load_ops;
  logic             bypass;
  logic [WIDTH-1:0] bypass_val;
  logic             capture;
  logic             timeout_hit;
  logic             timeout_now;

`ifdef GCD_SEQ_TIMEOUT_EN
  // Held at zero outside SEND_B, so it is cleared on every entry to SEND_B.
  logic [31:0] wd_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state != SEND_B) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th cycle of SEND_B, so req is high exactly
  // TIMEOUT_CYCLES cycles before it is dropped.
  assign timeout_now = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign timeout_now        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_ops    = 1'b0;
    bypass      = 1'b0;
    bypass_val  = '0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load_ops = 1'b1;
          // The engine never terminates on a zero operand, so answer here.
          // A==0 also covers A==B==0 (result is B, which is 0).
          if (bus.in_a == '0) begin
            bypass     = 1'b1;
            bypass_val = bus.in_b;
            state_nxt  = DONE;
          end else if (bus.in_b == '0) begin
            bypass     = 1'b1;
            bypass_val = bus.in_a;
            state_nxt  = DONE;
          end else begin
            state_nxt = SEND_A;
          end
        end
      end
      SEND_A: begin
        if (bus.gcd_ack) state_nxt = REL_A;
      end
      REL_A: begin
        if (!bus.gcd_ack) state_nxt = SEND_B;
      end
      SEND_B: begin
        // A real ack wins over a watchdog expiry in the same cycle.
        if (bus.gcd_ack) begin
          capture   = 1'b1;
          state_nxt = REL_B;
        end else if (timeout_now) begin
          timeout_hit = 1'b1;
          state_nxt   = REL_B;
        end
      end
      REL_B: begin
        if (!bus.gcd_ack) state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra    <= '0;
      rb    <= '0;
      res_q <= '0;
      to_q  <= 1'b0;
    end else begin
      if (load_ops) begin
        ra   <= bus.in_a;
        rb   <= bus.in_b;
        to_q <= 1'b0;
      end
      if (bypass)  res_q <= bypass_val;
      if (capture) res_q <= bus.gcd_c;
      if (timeout_hit) begin
        res_q <= '0;
        to_q  <= 1'b1;
      end
    end
  end

  // All outputs come from state and registers only.
  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.gcd_req     = (state == SEND_A) || (state == SEND_B);
  // AB flips to B only on REL_A->SEND_B (ack already low) and stays on B
  // through REL_B/DONE so it never moves while the engine holds ack.
  assign bus.gcd_ab      = ((state == SEND_B) || (state == REL_B) || (state == DONE)) ? rb : ra;
  assign bus.out_result  = res_q;
  assign bus.out_timeout = to_q;

endmodule
